bram_voice_arbiter: RTL and testbench
=====================================

# bram_voice_arbiter

Read-only scheduler that shares the single BRAM port between up to NUM_REQ voice loaders. Each loader requests a burst of NUM_WORDS consecutive 32-bit words from its own base address. The arbiter grants one requester at a time, sequences the BRAM port, and streams the returned words with their buffer indices to the granted loader. It sits between the PS-visible BRAM and the per-voice sample buffers that feed the I2S players, replacing each player's private BRAM sequencer.

## Interface
- NUM_REQ, 4, number of requesting voice loaders (2..8)
- NUM_WORDS, 256, words per burst (power of two)
- BRAM_DELAY, 2, BRAM read latency in clk cycles (1..3)
- IDX_W, $clog2(NUM_WORDS), width of wr_index

- clk  in  1  system clock; also drives BRAM_clk
- rst_n  in  1  reset, asynchronous assert, active-low
- req  in  NUM_REQ  level request per loader; held until done
- base_addr  in  NUM_REQ*32  byte base address per loader, slice i = [32*i+31:32*i]; word-aligned
- grant  out  NUM_REQ  one-hot; high for the whole burst of the winner
- done  out  NUM_REQ  one-cycle pulse to the winner at burst end
- busy  out  1  high from grant through done
- wr_valid  out  1  wr_data/wr_index valid for the granted loader
- wr_index  out  IDX_W  buffer index 0..NUM_WORDS-1
- wr_data  out  32  word read from BRAM
- BRAM_addr  out  32  byte address
- BRAM_clk  out  1  = clk
- BRAM_din  out  32  constant 0
- BRAM_dout  in  32  read data
- BRAM_en  out  1  port enable
- BRAM_rst  out  1  port reset
- BRAM_we  out  4  constant 0

## Operation
- States: IDLE, ISSUE, DRAIN, DONE.
- IDLE: BRAM_en=0. If any req bit is set, select a winner, set grant, load BRAM_addr=base_addr[winner], zero the issue and return counters, and go to ISSUE.
- ISSUE: BRAM_en=1. BRAM_addr advances by 4 each cycle. After NUM_WORDS addresses have been presented, go to DRAIN.
- DRAIN: BRAM_en=0. Hold BRAM_addr. Stay until the return counter reaches NUM_WORDS, then go to DONE.
- Return path: a BRAM_DELAY-deep shift register of valid bits tracks issued reads. On each returning word, wr_valid=1, wr_data=BRAM_dout, and wr_index=return counter, which then increments.
- DONE: pulse done[winner]. Clear grant and busy. Update the round-robin pointer to winner+1 mod NUM_REQ. Go to IDLE.
- Arbitration: round-robin, starting the search at the pointer. Pointer resets to 0.
- Bursts cannot be aborted. Dropping req mid-burst is ignored and the burst completes normally. A req still high in the cycle after DONE is treated as a new request.
- base_addr is sampled only at grant.
- Address arithmetic is 32-bit and wraps modulo 2^32 without a flag.

## Timing
- Reset values: grant=0, done=0, busy=0, wr_valid=0, wr_index=0, wr_data=0, BRAM_addr=0, BRAM_en=0, BRAM_rst=1, BRAM_we=0, BRAM_din=0, state=IDLE, pointer=0.
- BRAM_rst deasserts on the first clk edge after rst_n rises.
- Let G be the first ISSUE cycle:
  - req sampled in IDLE at cycle G-1.
  - Addresses are presented on cycles G..G+NUM_WORDS-1.
  - wr_valid is high on cycles G+BRAM_DELAY..G+BRAM_DELAY+NUM_WORDS-1, contiguous.
  - done is high on cycle G+NUM_WORDS+BRAM_DELAY.
  - The next grant is no earlier than G+NUM_WORDS+BRAM_DELAY+2.
- Reset mid-burst: all outputs return to reset values immediately. No done is issued and no partial-burst state is kept.

## Configuration
- BRAM_ARB_FIXED_PRIO_EN defined: fixed priority, lowest req index wins, and the pointer logic is removed.
- Not defined: round-robin as described under Operation.

## Structure
- Package bram_arb_pkg holds:
  - arb_state_t (IDLE, ISSUE, DRAIN, DONE)
  - BRAM_ADDR_INCREMENT = 4
  - a function returning the one-hot winner from req and pointer
- One sub-module, rr_arbiter: combinational winner select from req and pointer, plus the registered pointer. The macro selects its body.

## Test plan
Benches run with NUM_REQ=4, NUM_WORDS=4, BRAM_DELAY=2, and a BRAM model returning data = address.
- Single request: req=0001, base=0x100 -> BRAM_addr 0x100,0x104,0x108,0x10C; wr_data in the same order with wr_index 0..3; done[0] on cycle G+6.
- All four requesting continuously -> grant order 0,1,2,3,0. With BRAM_ARB_FIXED_PRIO_EN defined -> grant 0 repeatedly.
- req[1] dropped at G+1 -> burst still yields 4 wr_valid beats and done[1].
- rst_n low at G+3 -> next cycle shows all outputs at reset values and BRAM_rst=1. After release, a fresh request starts at its base address with wr_index 0.
- base=0xFFFFFFF8 -> addresses 0xFFFFFFF8, 0xFFFFFFFC, 0x0, 0x4.
- req[2] and req[3] rise together with pointer=3 -> grant[3] first, then grant[2].

Source files
------------

// File: rtl/bram_arb_pkg.sv
// rtl/bram_arb_pkg.sv - shared types, constants and winner-select function for the BRAM voice arbiter
package bram_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } arb_state_t;

  localparam logic [31:0] BRAM_ADDR_INCREMENT = 32'd4;
  localparam int          MAX_REQ             = 8;

  // First set req bit found scanning upward from ptr, wrapping at n; returned one-hot
  function automatic logic [MAX_REQ-1:0] rr_pick(input logic [MAX_REQ-1:0] req,
                                                 input logic [2:0]         ptr,
                                                 input logic [31:0]        n);
    logic [MAX_REQ-1:0] onehot;
    logic               found;
    logic [31:0]        idx;
    onehot = '0;
    found  = 1'b0;
    for (int k = 0; k < MAX_REQ; k++) begin
      idx = ({29'd0, ptr} + 32'(k)) % n;
      if ((32'(k) < n) && !found && req[idx[2:0]]) begin
        onehot[idx[2:0]] = 1'b1;
        found            = 1'b1;
      end
    end
    return onehot;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - winner select plus registered round-robin pointer; BRAM_ARB_FIXED_PRIO_EN selects fixed priority
module rr_arbiter
  import bram_arb_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] i_req,
  input  logic               i_advance,
  input  logic [2:0]         i_win_idx,
  output logic [NUM_REQ-1:0] o_winner,
  output logic [2:0]         o_winner_idx
);

  logic [MAX_REQ-1:0] w_req_ext;
  logic [MAX_REQ-1:0] w_pick;

  // Widen the request vector to the function's fixed width
  always_comb begin
    w_req_ext                = '0;
    w_req_ext[NUM_REQ-1:0]   = i_req;
  end

`ifdef BRAM_ARB_FIXED_PRIO_EN
  logic w_unused;
  assign w_unused = ^{clk, rst_n, i_advance, i_win_idx};
  assign w_pick   = rr_pick(w_req_ext, 3'd0, NUM_REQ);
`else
  logic [2:0] r_ptr;

  // Pointer moves to the slot after the finished winner
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= 3'd0;
    end else if (i_advance) begin
      r_ptr <= (i_win_idx == 3'(NUM_REQ - 1)) ? 3'd0 : i_win_idx + 3'd1;
    end
  end

  assign w_pick = rr_pick(w_req_ext, r_ptr, NUM_REQ);
`endif

  // One-hot winner and its binary index
  always_comb begin
    o_winner_idx = 3'd0;
    for (int i = 0; i < MAX_REQ; i++) begin
      if (w_pick[i]) o_winner_idx = 3'(i);
    end
    o_winner = w_pick[NUM_REQ-1:0];
  end

endmodule

// File: rtl/bram_voice_arbiter.sv
// rtl/bram_voice_arbiter.sv - shares one BRAM read port among voice loaders in bursts; BRAM_ARB_FIXED_PRIO_EN selects fixed priority
module bram_voice_arbiter
  import bram_arb_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int NUM_WORDS  = 256,
  parameter int BRAM_DELAY = 2,
  parameter int IDX_W      = $clog2(NUM_WORDS)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [NUM_REQ*32-1:0] base_addr,
  output logic [NUM_REQ-1:0]   grant,
  output logic [NUM_REQ-1:0]   done,
  output logic                 busy,
  output logic                 wr_valid,
  output logic [IDX_W-1:0]     wr_index,
  output logic [31:0]          wr_data,
  output logic [31:0]          BRAM_addr,
  output logic                 BRAM_clk,
  output logic [31:0]          BRAM_din,
  input  logic [31:0]          BRAM_dout,
  output logic                 BRAM_en,
  output logic                 BRAM_rst,
  output logic [3:0]           BRAM_we
);

  localparam logic [IDX_W:0] LAST_WORD = (IDX_W + 1)'(NUM_WORDS - 1);

  arb_state_t            r_state;
  logic [NUM_REQ-1:0]    r_grant;
  logic [NUM_REQ-1:0]    r_done;
  logic                  r_busy;
  logic [31:0]           r_addr;
  logic                  r_en;
  logic                  r_bram_rst;
  logic [IDX_W:0]        r_iss_cnt;
  logic [IDX_W:0]        r_ret_cnt;
  logic [2:0]            r_win_idx;
  logic [BRAM_DELAY-1:0] r_vld_sr;

  logic [NUM_REQ-1:0]    w_winner;
  logic [2:0]            w_win_idx;
  logic [31:0]           w_base;
  logic                  w_ret_valid;
  logic                  w_ptr_adv;

  assign w_ret_valid = r_vld_sr[BRAM_DELAY-1];
  assign w_ptr_adv   = (r_state == DONE);

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr_arbiter (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_req        (req),
    .i_advance    (w_ptr_adv),
    .i_win_idx    (r_win_idx),
    .o_winner     (w_winner),
    .o_winner_idx (w_win_idx)
  );

  // Base address of the would-be winner, captured only at grant
  always_comb begin
    w_base = 32'd0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_winner[i]) w_base = base_addr[32*i +: 32];
    end
  end

  // Burst sequencer: grant, issue NUM_WORDS reads, wait for the last return, pulse done
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_grant   <= '0;
      r_done    <= '0;
      r_busy    <= 1'b0;
      r_addr    <= 32'd0;
      r_en      <= 1'b0;
      r_iss_cnt <= '0;
      r_ret_cnt <= '0;
      r_win_idx <= 3'd0;
    end else begin
      r_done <= '0;
      if (w_ret_valid) r_ret_cnt <= r_ret_cnt + 1'b1;
      case (r_state)
        IDLE: begin
          if (|req) begin
            r_grant   <= w_winner;
            r_win_idx <= w_win_idx;
            r_busy    <= 1'b1;
            r_addr    <= w_base;
            r_en      <= 1'b1;
            r_iss_cnt <= '0;
            r_ret_cnt <= '0;
            r_state   <= ISSUE;
          end
        end
        ISSUE: begin
          r_iss_cnt <= r_iss_cnt + 1'b1;
          if (r_iss_cnt == LAST_WORD) begin
            r_en    <= 1'b0;
            r_state <= DRAIN;
          end else begin
            r_addr <= r_addr + BRAM_ADDR_INCREMENT;
          end
        end
        DRAIN: begin
          if (w_ret_valid && (r_ret_cnt == LAST_WORD)) begin
            r_done  <= r_grant;
            r_state <= DONE;
          end
        end
        DONE: begin
          r_grant <= '0;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Valid-bit pipeline matching the BRAM read latency
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld_sr <= '0;
    end else begin
      r_vld_sr[0] <= r_en;
      for (int k = 1; k < BRAM_DELAY; k++) r_vld_sr[k] <= r_vld_sr[k-1];
    end
  end

  // Port reset held through reset and dropped on the first clock after release
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_bram_rst <= 1'b1;
    else        r_bram_rst <= 1'b0;
  end

  assign grant     = r_grant;
  assign done      = r_done;
  assign busy      = r_busy;
  assign wr_valid  = w_ret_valid;
  assign wr_index  = r_ret_cnt[IDX_W-1:0];
  assign wr_data   = w_ret_valid ? BRAM_dout : 32'd0;
  assign BRAM_addr = r_addr;
  assign BRAM_clk  = clk;
  assign BRAM_din  = 32'd0;
  assign BRAM_en   = r_en;
  assign BRAM_rst  = r_bram_rst;
  assign BRAM_we   = 4'd0;

endmodule

// File: tb/tb_bram_voice_arbiter.sv
// tb/tb_bram_voice_arbiter.sv - self-checking bench for bram_voice_arbiter (either setting of BRAM_ARB_FIXED_PRIO_EN)
module tb_bram_voice_arbiter;

  localparam int NR  = 4;
  localparam int NW  = 4;
  localparam int DLY = 2;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [NR-1:0]   req = '0;
  logic [NR*32-1:0] base_addr = '0;
  logic [NR-1:0]   grant, done;
  logic            busy, wr_valid;
  logic [1:0]      wr_index;
  logic [31:0]     wr_data, BRAM_addr, BRAM_din, BRAM_dout;
  logic            BRAM_clk, BRAM_en, BRAM_rst;
  logic [3:0]      BRAM_we;

  logic [31:0]     bram_pipe [DLY];

  int n_checks = 0;
  int n_errors = 0;
  int model_ptr = 0;

  // captured burst
  int          cap_wait, cap_n_addr, cap_n_wr, cap_done_t, cap_end_t;
  bit          cap_timeout, cap_grant_changed;
  logic [3:0]  cap_grant, cap_done_val, cap_grant_after;
  logic [31:0] cap_addr [16];
  int          cap_addr_t [16];
  logic [31:0] cap_wd [16];
  logic [1:0]  cap_wi [16];
  int          cap_wt [16];

  bram_voice_arbiter #(.NUM_REQ(NR), .NUM_WORDS(NW), .BRAM_DELAY(DLY)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .base_addr(base_addr),
    .grant(grant), .done(done), .busy(busy), .wr_valid(wr_valid),
    .wr_index(wr_index), .wr_data(wr_data), .BRAM_addr(BRAM_addr),
    .BRAM_clk(BRAM_clk), .BRAM_din(BRAM_din), .BRAM_dout(BRAM_dout),
    .BRAM_en(BRAM_en), .BRAM_rst(BRAM_rst), .BRAM_we(BRAM_we)
  );

  always #5 clk = ~clk;

  // BRAM model: data = address, DLY cycles after the address is presented
  always @(posedge clk) begin
    bram_pipe[0] <= BRAM_en ? BRAM_addr : 32'hDEADBEEF;
    for (int k = 1; k < DLY; k++) bram_pipe[k] <= bram_pipe[k-1];
  end
  assign BRAM_dout = bram_pipe[DLY-1];

  function automatic logic [3:0] model_pick(input logic [3:0] r, input int p);
    int i;
`ifdef BRAM_ARB_FIXED_PRIO_EN
    for (int k = 0; k < NR; k++) if (r[k]) return 4'(1) << k;
`else
    for (int k = 0; k < NR; k++) begin
      i = (p + k) % NR;
      if (r[i]) return 4'(1) << i;
    end
`endif
    return 4'd0;
  endfunction

  function automatic int idx_of(input logic [3:0] g);
    for (int i = 0; i < NR; i++) if (g[i]) return i;
    return 0;
  endfunction

  task automatic set_base(input int i, input logic [31:0] v);
    base_addr[32*i +: 32] = v;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req   = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_ptr = 0;
  endtask

  // Record one burst as seen at negedges; optionally drop req bits or release the winner at done
  task automatic observe(input logic [3:0] drop_mask, input int drop_at, input bit release_on_done);
    int w;
    cap_n_addr = 0; cap_n_wr = 0; cap_done_t = -1; cap_end_t = -1;
    cap_done_val = '0; cap_timeout = 1'b0; cap_grant_changed = 1'b0; cap_grant_after = 'x;
    w = 0;
    while (busy !== 1'b1 && w < 100) begin
      @(negedge clk);
      w++;
    end
    cap_wait = w;
    if (busy !== 1'b1) begin
      cap_timeout = 1'b1;
      return;
    end
    cap_grant = grant;
    for (int t = 0; t < 40; t++) begin
      if (t > 0 && busy !== 1'b1) begin
        cap_end_t = t;
        cap_grant_after = grant;
        break;
      end
      if (grant !== cap_grant) cap_grant_changed = 1'b1;
      if (BRAM_en === 1'b1 && cap_n_addr < 16) begin
        cap_addr[cap_n_addr] = BRAM_addr; cap_addr_t[cap_n_addr] = t; cap_n_addr++;
      end
      if (wr_valid === 1'b1 && cap_n_wr < 16) begin
        cap_wd[cap_n_wr] = wr_data; cap_wi[cap_n_wr] = wr_index; cap_wt[cap_n_wr] = t; cap_n_wr++;
      end
      if (done !== '0) begin
        cap_done_t = t; cap_done_val = done;
        if (release_on_done) req = req & ~done;
      end
      if (t == drop_at) req = req & ~drop_mask;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (grant !== 0 || done !== 0 || busy !== 0 || wr_valid !== 0 || wr_index !== 0 || wr_data !== 0 ||
        BRAM_addr !== 0 || BRAM_en !== 0 || BRAM_rst !== 1 || BRAM_we !== 0 || BRAM_din !== 0) begin
      n_errors++;
      $display("FAIL reset_values: grant=%b done=%b busy=%b wv=%b wi=%0d wd=%h addr=%h en=%b rst=%b we=%h din=%h, want all 0 and rst=1",
               grant, done, busy, wr_valid, wr_index, wr_data, BRAM_addr, BRAM_en, BRAM_rst, BRAM_we, BRAM_din);
    end
    rst_n = 1'b1;
    #1;
    n_checks++;
    if (BRAM_rst !== 1'b1) begin n_errors++; $display("FAIL bram_rst_before_edge: got %b want 1", BRAM_rst); end
    @(negedge clk);
    n_checks++;
    if (BRAM_rst !== 1'b0) begin n_errors++; $display("FAIL bram_rst_after_edge: got %b want 0", BRAM_rst); end
    model_ptr = 0;
  endtask

  task automatic test_single();
    logic [3:0] exp_g; logic [31:0] b;
    b = 32'h100; set_base(0, b); req = 4'b0001;
    exp_g = model_pick(req, model_ptr);
    observe(4'b0, -1, 1'b1);
    n_checks++;
    if (cap_timeout || cap_grant !== exp_g || cap_grant_changed || cap_wait != 1) begin
      n_errors++; $display("FAIL single_grant: got %b wait %0d, want %b wait 1", cap_grant, cap_wait, exp_g);
    end
    n_checks++;
    if (cap_n_addr != NW || cap_n_wr != NW) begin
      n_errors++; $display("FAIL single_count: addr %0d wr %0d, want %0d", cap_n_addr, cap_n_wr, NW);
    end
    for (int k = 0; k < NW; k++) begin
      n_checks++;
      if (cap_addr[k] !== b + 32'(4*k) || cap_addr_t[k] != k) begin
        n_errors++; $display("FAIL single_addr%0d: got %h@%0d want %h@%0d", k, cap_addr[k], cap_addr_t[k], b + 32'(4*k), k);
      end
      n_checks++;
      if (cap_wd[k] !== b + 32'(4*k) || cap_wi[k] !== 2'(k) || cap_wt[k] != DLY + k) begin
        n_errors++; $display("FAIL single_wr%0d: got %h idx %0d @%0d want %h idx %0d @%0d",
                             k, cap_wd[k], cap_wi[k], cap_wt[k], b + 32'(4*k), k, DLY + k);
      end
    end
    n_checks++;
    if (cap_done_t != NW + DLY || cap_done_val !== exp_g || cap_end_t != NW + DLY + 1 || cap_grant_after !== 4'd0) begin
      n_errors++; $display("FAIL single_done: done %b @%0d end @%0d grant_after %b, want %b @%0d end @%0d grant 0",
                           cap_done_val, cap_done_t, cap_end_t, cap_grant_after, exp_g, NW + DLY, NW + DLY + 1);
    end
    req = '0;
    model_ptr = (idx_of(exp_g) + 1) % NR;
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_g; logic [31:0] b;
    do_reset();
    for (int i = 0; i < NR; i++) set_base(i, $urandom & 32'hFFFF_FFFC);
    @(negedge clk);
    req = 4'b1111;
    for (int n = 0; n < 5; n++) begin
      exp_g = model_pick(req, model_ptr);
      b = base_addr[32*idx_of(exp_g) +: 32];
      observe(4'b0, -1, 1'b0);
      n_checks++;
      if (cap_timeout || cap_grant !== exp_g || cap_grant_changed || cap_wait != 1) begin
        n_errors++; $display("FAIL rr_grant%0d: got %b wait %0d, want %b wait 1", n, cap_grant, cap_wait, exp_g);
      end
      n_checks++;
      if (cap_n_addr != NW || cap_n_wr != NW || cap_addr[0] !== b || cap_wd[NW-1] !== b + 32'(4*(NW-1)) ||
          cap_wi[NW-1] !== 2'(NW-1)) begin
        n_errors++; $display("FAIL rr_beats%0d: n %0d/%0d first %h last %h idx %0d, want base %h", n,
                             cap_n_addr, cap_n_wr, cap_addr[0], cap_wd[NW-1], cap_wi[NW-1], b);
      end
      n_checks++;
      if (cap_done_t != NW + DLY || cap_done_val !== exp_g) begin
        n_errors++; $display("FAIL rr_done%0d: got %b @%0d want %b @%0d", n, cap_done_val, cap_done_t, exp_g, NW + DLY);
      end
      model_ptr = (idx_of(exp_g) + 1) % NR;
    end
    req = '0;
  endtask

  task automatic test_drop();
    logic [3:0] exp_g;
    @(negedge clk);
    set_base(1, 32'h2000);
    req = 4'b0010;
    exp_g = model_pick(req, model_ptr);
    observe(4'b0010, 1, 1'b0);
    n_checks++;
    if (cap_timeout || cap_grant !== 4'b0010 || cap_grant_changed) begin
      n_errors++; $display("FAIL drop_grant: got %b want %b", cap_grant, exp_g);
    end
    n_checks++;
    if (cap_n_wr != NW || cap_wd[NW-1] !== 32'h2000 + 32'(4*(NW-1)) || cap_wt[NW-1] != DLY + NW - 1) begin
      n_errors++; $display("FAIL drop_beats: got %0d beats last %h @%0d, want %0d", cap_n_wr, cap_wd[NW-1], cap_wt[NW-1], NW);
    end
    n_checks++;
    if (cap_done_val !== exp_g || cap_done_t != NW + DLY) begin
      n_errors++; $display("FAIL drop_done: got %b @%0d want %b @%0d", cap_done_val, cap_done_t, exp_g, NW + DLY);
    end
    req = '0;
    model_ptr = (idx_of(exp_g) + 1) % NR;
  endtask

  task automatic test_wrap();
    logic [3:0] exp_g; logic [31:0] b;
    @(negedge clk);
    b = 32'hFFFF_FFF8; set_base(0, b); req = 4'b0001;
    exp_g = model_pick(req, model_ptr);
    observe(4'b0, -1, 1'b1);
    n_checks++;
    if (cap_timeout || cap_grant !== exp_g || cap_n_addr != NW) begin
      n_errors++; $display("FAIL wrap_grant: got %b n %0d want %b n %0d", cap_grant, cap_n_addr, exp_g, NW);
    end
    for (int k = 0; k < NW; k++) begin
      n_checks++;
      if (cap_addr[k] !== b + 32'(4*k) || cap_wd[k] !== b + 32'(4*k)) begin
        n_errors++; $display("FAIL wrap_addr%0d: got addr %h data %h want %h", k, cap_addr[k], cap_wd[k], b + 32'(4*k));
      end
    end
    req = '0;
    model_ptr = (idx_of(exp_g) + 1) % NR;
  endtask

  task automatic test_tie();
    logic [3:0] exp_g;
    do_reset();
    set_base(2, 32'h3000); set_base(3, 32'h4000);
    @(negedge clk);
    req = 4'b0100;
    exp_g = model_pick(req, model_ptr);
    observe(4'b0, -1, 1'b1);
    model_ptr = (idx_of(exp_g) + 1) % NR;
    @(negedge clk);
    req = 4'b1100;
    for (int n = 0; n < 2; n++) begin
      exp_g = model_pick(req, model_ptr);
      observe(4'b0, -1, 1'b1);
      n_checks++;
      if (cap_timeout || cap_grant !== exp_g || cap_done_val !== exp_g ||
          cap_addr[0] !== base_addr[32*idx_of(exp_g) +: 32]) begin
        n_errors++; $display("FAIL tie_grant%0d: got %b done %b addr %h want %b", n, cap_grant, cap_done_val, cap_addr[0], exp_g);
      end
      model_ptr = (idx_of(exp_g) + 1) % NR;
    end
    req = '0;
  endtask

  task automatic test_reset_mid();
    logic [3:0] exp_g; logic [31:0] b; int w;
    @(negedge clk);
    set_base(2, 32'h5000); req = 4'b0100;
    w = 0;
    while (busy !== 1'b1 && w < 100) begin @(negedge clk); w++; end
    n_checks++;
    if (busy !== 1'b1) begin n_errors++; $display("FAIL rstmid_start: busy %b want 1", busy); end
    repeat (3) @(negedge clk);
    rst_n = 1'b0; req = '0;
    #1;
    n_checks++;
    if (grant !== 0 || done !== 0 || busy !== 0 || wr_valid !== 0 || wr_index !== 0 || wr_data !== 0 ||
        BRAM_addr !== 0 || BRAM_en !== 0 || BRAM_rst !== 1) begin
      n_errors++; $display("FAIL rstmid_values: grant=%b done=%b busy=%b wv=%b wi=%0d wd=%h addr=%h en=%b rst=%b",
                           grant, done, busy, wr_valid, wr_index, wr_data, BRAM_addr, BRAM_en, BRAM_rst);
    end
    @(negedge clk);
    n_checks++;
    if (done !== 0 || wr_valid !== 0 || BRAM_rst !== 1) begin
      n_errors++; $display("FAIL rstmid_hold: done=%b wv=%b rst=%b want 0 0 1", done, wr_valid, BRAM_rst);
    end
    rst_n = 1'b1; model_ptr = 0;
    @(negedge clk);
    b = $urandom & 32'hFFFF_FFFC; set_base(1, b); req = 4'b0010;
    exp_g = model_pick(req, model_ptr);
    observe(4'b0, -1, 1'b1);
    n_checks++;
    if (cap_timeout || cap_grant !== exp_g || cap_n_wr != NW) begin
      n_errors++; $display("FAIL rstmid_restart: grant %b beats %0d want %b %0d", cap_grant, cap_n_wr, exp_g, NW);
    end
    for (int k = 0; k < NW; k++) begin
      n_checks++;
      if (cap_addr[k] !== b + 32'(4*k) || cap_wd[k] !== b + 32'(4*k) || cap_wi[k] !== 2'(k)) begin
        n_errors++; $display("FAIL rstmid_beat%0d: addr %h data %h idx %0d want %h idx %0d", k, cap_addr[k], cap_wd[k], cap_wi[k], b + 32'(4*k), k);
      end
    end
    n_checks++;
    if (cap_done_val !== exp_g || cap_done_t != NW + DLY) begin
      n_errors++; $display("FAIL rstmid_done: got %b @%0d want %b @%0d", cap_done_val, cap_done_t, exp_g, NW + DLY);
    end
    req = '0;
    model_ptr = (idx_of(exp_g) + 1) % NR;
  endtask

  task automatic test_random();
    logic [3:0] exp_g; logic [31:0] b; int guard;
    for (int r = 0; r < 6; r++) begin
      repeat ($urandom_range(1, 3)) @(negedge clk);
      for (int i = 0; i < NR; i++) set_base(i, $urandom & 32'hFFFF_FFFC);
      req = 4'($urandom_range(1, 15));
      guard = 0;
      while (req != 0 && guard < 8) begin
        guard++;
        exp_g = model_pick(req, model_ptr);
        b = base_addr[32*idx_of(exp_g) +: 32];
        observe(4'b0, -1, 1'b1);
        n_checks++;
        if (cap_timeout || cap_grant !== exp_g || cap_grant_changed || cap_wait != 1) begin
          n_errors++; $display("FAIL rand_grant%0d: got %b wait %0d want %b wait 1", r, cap_grant, cap_wait, exp_g);
        end
        for (int k = 0; k < NW; k++) begin
          n_checks++;
          if (cap_addr[k] !== b + 32'(4*k) || cap_wd[k] !== b + 32'(4*k) || cap_wi[k] !== 2'(k) || cap_wt[k] != DLY + k) begin
            n_errors++; $display("FAIL rand_beat%0d_%0d: addr %h data %h idx %0d @%0d want %h", r, k,
                                 cap_addr[k], cap_wd[k], cap_wi[k], cap_wt[k], b + 32'(4*k));
          end
        end
        n_checks++;
        if (cap_done_val !== exp_g || cap_done_t != NW + DLY || cap_end_t != NW + DLY + 1) begin
          n_errors++; $display("FAIL rand_done%0d: got %b @%0d end %0d want %b @%0d", r, cap_done_val, cap_done_t, cap_end_t, exp_g, NW + DLY);
        end
        model_ptr = (idx_of(exp_g) + 1) % NR;
      end
      req = '0;
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_drop();
    test_wrap();
    test_tie();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
